// File: rtl/dtcm_ahb_responder.sv
// dtcm_ahb_responder: AHB-Lite data TCM with wait states, ERROR responses, byte-lane writes
// and a saturating error counter.
module dtcm_ahb_responder #(
   parameter int          DEPTH       = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
   parameter int          WAIT_STATES = 0
) (
   input  logic        hclk,
   input  logic        hrst,
   input  logic [31:0] haddr,
   input  logic        hwrite,
   input  logic [31:0] hwdata,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic [6:0]  hprot,
   input  logic [1:0]  htrans,
   input  logic        hmastlock,
   output logic        hready,
   output logic        hresp,
   output logic [31:0] hrdata,
   input  logic        pl_we,
   input  logic [31:0] pl_addr,
   input  logic [31:0] pl_wdata,
   output logic [7:0]  err_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
   state_t state, state_nx;
   logic [31:0] mem [DEPTH];
   logic [31:0] off, rd_word, wr_word;
   logic [AW-1:0] cur_idx, dp_idx, ld_idx;
   logic [3:0] cnt, cnt_nx, cur_be, dp_be;
   logic accept, err, commit, load, wait_done, dp_wr, dp_rd, unused_ok;

   assign off = haddr - BASE_ADDR;
   assign cur_idx = off[AW+1:2];
   assign cur_be = hsize == 3'd0 ? 4'b0001 << haddr[1:0] :
                   hsize == 3'd1 ? (haddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign err = hsize > 3'd2 || haddr < BASE_ADDR || {1'b0, haddr} >= LIMIT ||
                (hsize == 3'd1 && haddr[0]) || (hsize == 3'd2 && haddr[1:0] != 2'b00);
   assign hready = state == IDLE || state == ERR2;
   assign hresp = state == ERR1 || state == ERR2;
   assign accept = hready && htrans[1];
   assign commit = hready && dp_wr;
   assign wait_done = state == WAIT && cnt == 4'(WAIT_STATES - 1);
   // Zero-wait reads load straight from the address phase; waited reads load as WAIT exits.
   assign load = WAIT_STATES == 0 ? accept && !hwrite && !err : wait_done && dp_rd;
   assign ld_idx = WAIT_STATES == 0 ? cur_idx : dp_idx;
   assign unused_ok = ^{hburst, hprot, hmastlock, htrans[0], off[31:AW+2], off[1:0], pl_addr[31:AW]};

   always_comb begin
      rd_word = mem[ld_idx];
      wr_word = mem[dp_idx];
      for (int i = 0; i < 4; i++)
         wr_word[8*i +: 8] = dp_be[i] ? hwdata[8*i +: 8] : mem[dp_idx][8*i +: 8];
   end

   always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      if (accept) begin
         state_nx = err ? ERR1 : WAIT_STATES > 0 ? WAIT : IDLE;
         cnt_nx = '0;
      end else if (state == WAIT) begin
         state_nx = wait_done ? IDLE : WAIT;
         cnt_nx = cnt + 4'd1;
      end else if (state != IDLE) begin
         state_nx = state == ERR1 ? ERR2 : IDLE;
      end
   end

   always_ff @(posedge hclk) begin
      if (hrst) begin
         state <= IDLE;
         cnt <= '0;
         dp_wr <= 1'b0;
         dp_rd <= 1'b0;
         dp_idx <= '0;
         dp_be <= '0;
         hrdata <= '0;
         err_cnt <= '0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         if (hready) begin
            dp_wr <= accept && hwrite && !err;
            dp_rd <= accept && !hwrite && !err;
            if (accept) begin
               dp_idx <= cur_idx;
               dp_be <= cur_be;
            end
         end
         // A write committing on the same edge forwards its merged word to the read.
         if (load) hrdata <= commit && ld_idx == dp_idx ? wr_word : rd_word;
         if (state == ERR2 && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
   end

   always_ff @(posedge hclk) begin
      if (pl_we) mem[pl_addr[AW-1:0]] <= pl_wdata;
      if (commit && !hrst) mem[dp_idx] <= wr_word;
   end
endmodule

// File: tb/tb_dtcm_ahb_responder.sv
// tb_dtcm_ahb_responder: scoreboard bench driving a zero-wait and a three-wait instance
// from shared stimulus; each task checks only the instance it targets.
module tb_dtcm_ahb_responder;
   logic hclk = 1'b0, hrst = 1'b1;
   logic [31:0] haddr = '0, hwdata = '0, pl_addr = '0, pl_wdata = '0;
   logic hwrite = 1'b0, hmastlock = 1'b0, pl_we = 1'b0;
   logic [2:0] hsize = '0, hburst = '0;
   logic [6:0] hprot = '0;
   logic [1:0] htrans = '0;
   logic hready0, hresp0, hready3, hresp3;
   logic [31:0] hrdata0, hrdata3;
   logic [7:0] err_cnt0, err_cnt3;
   typedef struct packed {logic wr; logic err; logic [31:0] data;} exp_t;
   exp_t exp_q[$];
   int total = 0, bad = 0, exp_cnt = 0;

   always #5 hclk = ~hclk;

   dtcm_ahb_responder #(.WAIT_STATES(0)) dut0 (
      .hclk(hclk), .hrst(hrst), .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata), .hsize(hsize),
      .hburst(hburst), .hprot(hprot), .htrans(htrans), .hmastlock(hmastlock), .hready(hready0),
      .hresp(hresp0), .hrdata(hrdata0), .pl_we(pl_we), .pl_addr(pl_addr), .pl_wdata(pl_wdata),
      .err_cnt(err_cnt0));

   dtcm_ahb_responder #(.WAIT_STATES(3)) dut3 (
      .hclk(hclk), .hrst(hrst), .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata), .hsize(hsize),
      .hburst(hburst), .hprot(hprot), .htrans(htrans), .hmastlock(hmastlock), .hready(hready3),
      .hresp(hresp3), .hrdata(hrdata3), .pl_we(pl_we), .pl_addr(pl_addr), .pl_wdata(pl_wdata),
      .err_cnt(err_cnt3));

   function automatic logic rdy(input bit d3);
      return d3 ? hready3 : hready0;
   endfunction

   task automatic idle(input int n);
      htrans = 2'b00;
      repeat (n) @(negedge hclk);
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      @(negedge hclk);
      pl_we = 1'b1; pl_addr = a; pl_wdata = d;
      @(negedge hclk);
      pl_we = 1'b0;
   endtask

   // One isolated transfer: address phase, data phase, scoreboard pop at the hready=1 cycle.
   task automatic xfer(input string nm, input bit d3, input logic [31:0] a, input bit wr,
                       input logic [2:0] sz, input logic [31:0] wd, input bit e, input logic [31:0] rd);
      int w = 0;
      int want_w;
      exp_t x;
      exp_q.push_back({wr, e, rd});
      @(negedge hclk);
      haddr = a; hwrite = wr; hsize = sz; htrans = 2'b10;
      @(negedge hclk);
      htrans = 2'b00; hwdata = wd;
      while (!rdy(d3) && w < 20) begin
         total++;
         if ((d3 ? hresp3 : hresp0) !== e) begin
            bad++;
            $display("FAIL %s stall_hresp got=%b want=%b", nm, d3 ? hresp3 : hresp0, e);
         end
         @(negedge hclk);
         w++;
      end
      x = exp_q.pop_front();
      want_w = x.err ? 1 : d3 ? 3 : 0;
      total++;
      if (w !== want_w) begin
         bad++;
         $display("FAIL %s wait_cycles got=%0d want=%0d", nm, w, want_w);
      end
      total++;
      if ((d3 ? hresp3 : hresp0) !== x.err) begin
         bad++;
         $display("FAIL %s hresp got=%b want=%b", nm, d3 ? hresp3 : hresp0, x.err);
      end
      if (!x.wr && !x.err) begin
         total++;
         if ((d3 ? hrdata3 : hrdata0) !== x.data) begin
            bad++;
            $display("FAIL %s hrdata got=%h want=%h", nm, d3 ? hrdata3 : hrdata0, x.data);
         end
      end
      if (x.err && !d3) exp_cnt = exp_cnt == 255 ? 255 : exp_cnt + 1;
   endtask

   task automatic test_reset;
      hrst = 1'b1;
      repeat (3) @(negedge hclk);
      total++;
      if ({hready0, hresp0, hrdata0, err_cnt0} !== {1'b1, 1'b0, 32'h0, 8'h0}) begin
         bad++;
         $display("FAIL reset0 got=%b/%b/%h/%0d want=1/0/0/0", hready0, hresp0, hrdata0, err_cnt0);
      end
      total++;
      if ({hready3, hresp3, hrdata3, err_cnt3} !== {1'b1, 1'b0, 32'h0, 8'h0}) begin
         bad++;
         $display("FAIL reset3 got=%b/%b/%h/%0d want=1/0/0/0", hready3, hresp3, hrdata3, err_cnt3);
      end
      hrst = 1'b0;
      exp_cnt = 0;
   endtask

   task automatic test_read;
      preload(0, 32'hDEAD_BEEF);
      xfer("rd_word0", 0, 32'h0001_0000, 0, 2, 0, 0, 32'hDEAD_BEEF);
      preload(1023, 32'h0BAD_F00D);
      xfer("rd_last", 0, 32'h0001_0FFC, 0, 2, 0, 0, 32'h0BAD_F00D);
      preload(32'h0000_0405, 32'h5555_AAAA);
      xfer("rd_pl_wrap", 0, 32'h0001_0014, 0, 2, 0, 0, 32'h5555_AAAA);
   endtask

   task automatic test_back_to_back;
      exp_t x;
      exp_q.push_back({1'b1, 1'b0, 32'h0});
      exp_q.push_back({1'b0, 1'b0, 32'hA5AD_BEEF});
      @(negedge hclk);
      haddr = 32'h0001_0003; hwrite = 1'b1; hsize = 3'd0; htrans = 2'b10;
      @(negedge hclk);
      hwdata = 32'hA55A_5A5A; haddr = 32'h0001_0000; hwrite = 1'b0; hsize = 3'd2;
      x = exp_q.pop_front();
      total++;
      if (hready0 !== 1'b1 || hresp0 !== x.err) begin
         bad++;
         $display("FAIL b2b_wr_done got=%b/%b want=1/%b", hready0, hresp0, x.err);
      end
      @(negedge hclk);
      htrans = 2'b00;
      x = exp_q.pop_front();
      total++;
      if (hrdata0 !== x.data) begin
         bad++;
         $display("FAIL b2b_bypass got=%h want=%h", hrdata0, x.data);
      end
      xfer("rd_after_byte", 0, 32'h0001_0000, 0, 2, 0, 0, 32'hA5AD_BEEF);
      preload(1, 32'h0);
      xfer("wr_half", 0, 32'h0001_0006, 1, 1, 32'h1234_9999, 0, 0);
      xfer("wr_byte0", 0, 32'h0001_0004, 1, 0, 32'h9999_9977, 0, 0);
      xfer("rd_lanes", 0, 32'h0001_0004, 0, 2, 0, 0, 32'h1234_0077);
   endtask

   task automatic test_preload_priority;
      preload(4, 32'h0);
      @(negedge hclk);
      haddr = 32'h0001_0010; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
      @(negedge hclk);
      htrans = 2'b00; hwdata = 32'hCAFE_F00D;
      pl_we = 1'b1; pl_addr = 32'd4; pl_wdata = 32'h1111_1111;
      @(negedge hclk);
      pl_we = 1'b0;
      xfer("bus_beats_pl", 0, 32'h0001_0010, 0, 2, 0, 0, 32'hCAFE_F00D);
   endtask

   task automatic test_wait;
      idle(6);
      preload(2, 32'h3333_C0DE);
      xfer("wait_rd", 1, 32'h0001_0008, 0, 2, 0, 0, 32'h3333_C0DE);
      xfer("wait_wr", 1, 32'h0001_000C, 1, 2, 32'h7777_8888, 0, 0);
      xfer("wait_rd2", 1, 32'h0001_000C, 0, 2, 0, 0, 32'h7777_8888);
   endtask

   task automatic test_error;
      idle(6);
      xfer("err_misalign", 0, 32'h0001_0002, 0, 2, 0, 1, 0);
      @(negedge hclk);
      total++;
      if (err_cnt0 !== 8'(exp_cnt)) begin
         bad++;
         $display("FAIL err_cnt_one got=%0d want=%0d", err_cnt0, exp_cnt);
      end
      xfer("err_wr_word", 0, 32'h0001_0002, 1, 2, 32'hFFFF_FFFF, 1, 0);
      xfer("err_wr_half", 0, 32'h0001_0001, 1, 1, 32'hFFFF_FFFF, 1, 0);
      xfer("ram_unchanged", 0, 32'h0001_0000, 0, 2, 0, 0, 32'hA5AD_BEEF);
   endtask

   task automatic test_saturate;
      xfer("err_above", 0, 32'h0001_1000, 0, 2, 0, 1, 0);
      xfer("err_below", 0, 32'h0000_FFFC, 0, 2, 0, 1, 0);
      xfer("err_hsize3", 0, 32'h0001_0000, 0, 3, 0, 1, 0);
      @(negedge hclk);
      total++;
      if (err_cnt0 !== 8'(exp_cnt)) begin
         bad++;
         $display("FAIL err_cnt_mid got=%0d want=%0d", err_cnt0, exp_cnt);
      end
      for (int i = 0; i < 300; i++)
         xfer("err_loop", 0, i[0] ? 32'h0001_1000 : 32'h0001_0000, 0, i[0] ? 3'd2 : 3'd3, 0, 1, 0);
      @(negedge hclk);
      total++;
      if (err_cnt0 !== 8'(exp_cnt)) begin
         bad++;
         $display("FAIL err_cnt_sat got=%0d want=%0d", err_cnt0, exp_cnt);
      end
   endtask

   task automatic test_reset_mid;
      idle(6);
      preload(8, 32'h1111_1111);
      @(negedge hclk);
      haddr = 32'h0001_0020; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
      @(negedge hclk);
      htrans = 2'b00; hwdata = 32'h2222_2222;
      hrst = 1'b1;
      @(negedge hclk);
      total++;
      if ({hready3, hresp3, hrdata3, err_cnt3} !== {1'b1, 1'b0, 32'h0, 8'h0}) begin
         bad++;
         $display("FAIL mid_reset got=%b/%b/%h/%0d want=1/0/0/0", hready3, hresp3, hrdata3, err_cnt3);
      end
      hrst = 1'b0;
      exp_cnt = 0;
      idle(2);
      xfer("abort_keep3", 1, 32'h0001_0020, 0, 2, 0, 0, 32'h1111_1111);
      xfer("abort_keep0", 0, 32'h0001_0020, 0, 2, 0, 0, 32'h1111_1111);
   endtask

   initial begin
      test_reset;
      test_read;
      test_back_to_back;
      test_preload_priority;
      test_wait;
      test_error;
      test_saturate;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule
